fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch front end for the 16-bit JPEB core. It drives the synchronous instruction memory and tracks the fetch PC. Fetched words are buffered in a small prefetch FIFO and handed to the decode/execute stage over a valid/ready handshake, together with their PC. It handles redirects from taken branches and jumps (`jalr`-style), and a halt request from execute.

## Interface
Parameters:
- `DEPTH`, 4, prefetch FIFO entries; power of two, at least 2.
- `RESET_PC`, 16'h0000, fetch PC loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  reset: synchronous, active-high.
- `imem_addr`  out  16  instruction address, word-addressed.
- `imem_ren`  out  1  read request; memory returns data the following cycle.
- `imem_rdata`  in  16  instruction word for the request issued the previous cycle.
- `redirect`  in  1  flush and restart fetch; single-cycle pulse.
- `redirect_pc`  in  16  new fetch PC, sampled when `redirect`=1.
- `halt`  in  1  level; stop issuing new requests while high.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready`  in  1  consumer accepts it this cycle.
- `out_instr`  out  16  instruction word.
- `out_pc`  out  16  address that instruction was fetched from.

## Operation
- State:
  - `fetch_pc`.
  - FIFO of {pc, instr} with `count`.
  - `inflight` bit, plus a registered copy of the issued PC.
- Issue: `imem_ren` = !rst && !redirect && !halt && (count + inflight < DEPTH).
  - When `imem_ren`=1: `imem_addr`=`fetch_pc`, and `fetch_pc` <= fetch_pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- Response: if `inflight` was set in the previous cycle, `imem_rdata` is pushed with its PC. The credit check guarantees a push never meets a full FIFO.
- Pop: when `out_valid && out_ready`; the oldest entry leaves.
- Simultaneous push and pop: both happen, and `count` is unchanged.
- Credit uses the registered `count`; a pop frees a slot only from the next cycle.
- Redirect, highest priority:
  - FIFO is emptied and `count`=0.
  - Any response arriving that cycle is discarded.
  - `inflight` is cleared, so the next cycle's `imem_rdata` is ignored.
  - `fetch_pc` <= `redirect_pc`.
  - No issue in the redirect cycle.
  - If `out_ready` is high in the redirect cycle, the handshake still counts as consumed, but the consumer must ignore it. Execute raises `redirect` only after completing its own instruction.
- Halt: issue stops, and the in-flight response still lands. The FIFO drains normally, and issue resumes at the unchanged `fetch_pc` when `halt` falls. Redirect overrides halt.
- Reset mid-operation: all contents and in-flight data are dropped.

## Timing
- Reset values:
  - `imem_ren`=0, `imem_addr`=`RESET_PC`.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - `count`=0, `inflight`=0.
- First `imem_ren`=1 occurs in the first cycle with `rst`=0.
- Fetch latency, issue in cycle t:
  - With bypass: `out_valid` in t+1.
  - Without bypass: `out_valid` in t+2.
- Redirect latency: redirect in cycle r, issue of `redirect_pc` in r+1, `out_valid` in r+2 (bypass) or r+3.
- Steady-state throughput is 1 instr/cycle when `out_ready`=1 and DEPTH≥2.
- FIFO pointers wrap modulo DEPTH.
- `out_*` hold stable while `out_valid && !out_ready`, with no redirect or reset.

## Configuration
- `FETCH_BYPASS_EN` defined: a response arriving into an empty FIFO is presented combinationally on `out_*` in the same cycle.
  - If it is accepted, it is not written to the FIFO.
  - If it is not accepted, it is written and presented next cycle.
- Undefined: every response is written to the FIFO first, and the output is driven only from registered FIFO state. This adds one cycle of latency and leaves no combinational path from `imem_rdata` to `out_*`.

## Structure
- Shared package `cpu_pkg`:
  - `word_t` (16-bit) typedef.
  - `RESET_PC_DEFAULT`.
  - Opcode constants reused by decode.
- One sub-module, `fetch_fifo`: parameterised DEPTH×32-bit sync FIFO with push, pop, flush, count and head outputs. `fetch_stage` holds the PC, credit, in-flight and bypass logic.

## Test plan
- Reset release, `out_ready`=1, memory holds word = address XOR 16'hA5A5:
  - Outputs pc 0,1,2,… with matching instructions.
  - One per cycle from cycle 1 (bypass) or 2.
- `out_ready`=0 for 10 cycles:
  - `imem_ren` stops after DEPTH outstanding entries.
  - `out_*` stable at pc 0.
  - On release, pcs 0..5 come out in order with no gaps or duplicates.
- Redirect to 16'h0040 while the FIFO holds 3 entries and one is in flight:
  - No stale pc is delivered.
  - Next delivered `out_pc`=16'h0040, at r+2 (bypass) or r+3.
- Redirect to 16'hFFFE, free-running: `out_pc` sequence FFFE, FFFF, 0000, 0001.
- Halt held 5 cycles mid-stream:
  - The in-flight word is delivered and no new `imem_ren` occurs.
  - Fetch resumes at the next sequential pc.
  - Halt plus a simultaneous redirect to 16'h0010 fetches 16'h0010 next cycle.
- `rst` pulsed with a full FIFO: `out_valid`=0 the cycle after, then the stream restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit JPEB core: machine word, reset PC,
// fetch FIFO entry layout and the opcode encoding used by decode.
package cpu_pkg;

    typedef logic [15:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_NAND = 4'h2,
        OP_LUI  = 4'h3,
        OP_SW   = 4'h4,
        OP_LW   = 4'h5,
        OP_BEQ  = 4'h6,
        OP_JALR = 4'h7
    } opcode_t;

    function automatic opcode_t opcode_of(input word_t instr);
        return opcode_t'(instr[15:12]);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched {pc, instr} entries; flush empties it in one cycle.
// Head is read combinationally from the entry the read pointer selects.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && !flush && wr_ptr_q == AW'(gi)) begin
                mem_q[gi] <= din;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// JPEB instruction fetch: PC, credit-based issue to sync imem, prefetch FIFO, redirect/halt.
// Define FETCH_BYPASS_EN to present a response into an empty FIFO on out_* in its arrival cycle.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_ren,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    word_t         fetch_pc_q, fetch_pc_d;
    word_t         issued_pc_q, issued_pc_d;
    logic          inflight_q, inflight_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fifo_head;
    fetch_entry_t  resp_entry;
    fetch_entry_t  out_entry;
    logic [CW:0]   slots_used;

    assign fifo_empty = (fifo_count == '0);
    assign resp_entry = '{pc: issued_pc_q, instr: imem_rdata};

    // Credit counts the word already in flight so its push can never overflow.
    assign slots_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign imem_ren   = !rst && !redirect && !halt && (slots_used < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = inflight_q && fifo_empty;
    assign out_valid = !fifo_empty || bypass;
    assign out_entry = bypass ? resp_entry : fifo_head;
    assign fifo_push = inflight_q && !redirect && !(bypass && out_ready);
`else
    assign out_valid = !fifo_empty;
    assign out_entry = fifo_head;
    assign fifo_push = inflight_q && !redirect;
`endif

    assign fifo_pop  = out_valid && out_ready && !fifo_empty;
    assign out_pc    = out_valid ? out_entry.pc    : 16'h0000;
    assign out_instr = out_valid ? out_entry.instr : 16'h0000;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = imem_ren;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_ren) begin
            fetch_pc_d  = fetch_pc_q + 16'h0001;
            issued_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (fifo_push),
        .din   (resp_entry),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table for startup/backpressure,
// hand-written sequences for redirect, PC wrap, halt and mid-stream reset.
module tb_fetch_stage;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_ren;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_instr;
    logic [15:0] out_pc;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_ren    (imem_ren),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    // Memory contents: word = address ^ A5A5, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= imem_addr ^ 16'hA5A5;
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        halt;
        logic        chk;
        logic        ren;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    bit          mon_en = 1'b0;
    logic [15:0] got_pc[$];
    logic [15:0] got_instr[$];
    int          got_cyc[$];
    int          r_cyc;
    int          resume_cyc;

    function automatic vec_t mk(input logic rst_i, input logic rdy_i, input logic halt_i,
                                input logic chk_i, input logic ren_i, input logic [15:0] addr_i,
                                input logic valid_i, input logic [15:0] pc_i);
        vec_t v;
        v.rst = rst_i; v.rdy = rdy_i; v.halt = halt_i; v.chk = chk_i;
        v.ren = ren_i; v.addr = addr_i; v.valid = valid_i; v.pc = pc_i;
        return v;
    endfunction

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task sample();
        if (mon_en && out_valid && out_ready && !redirect) begin
            got_pc.push_back(out_pc);
            got_instr.push_back(out_instr);
            got_cyc.push_back(cyc_cnt);
        end
    endtask

    task cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task clear_got();
        got_pc.delete();
        got_instr.delete();
        got_cyc.delete();
    endtask

    task do_reset();
        rst = 1'b1; redirect = 1'b0; halt = 1'b0; out_ready = 1'b1; mon_en = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task check_seq(input string name, input logic [15:0] start, input int n);
        logic [15:0] exp_pc;
        chk({name, "_count"}, 32'(got_pc.size() >= n), 32'd1);
        if (got_pc.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                exp_pc = start + 16'(i);
                chk({name, "_pc"}, 32'(got_pc[i]), 32'(exp_pc));
                chk({name, "_instr"}, 32'(got_instr[i]), 32'(exp_pc ^ 16'hA5A5));
            end
        end
    endtask

    initial begin
        // Startup, out_ready=1: fields are rst, rdy, halt, chk, ren, addr, valid, pc.
        vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 16'h0, 0, 16'h0));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(0, 1, 0, 1, 1, 16'(k), k >= LAT, k >= LAT ? 16'(k - LAT) : 16'h0));
        // Backpressure: out_ready=0 for 10 cycles, then release.
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h1, LAT == 1, 16'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h2, 1, 16'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h3, 1, 16'h0));
        for (int k = 4; k <= 9; k++)
            vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0, 1, 16'h0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0, 1, 16'h0));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(0, 1, 0, 1, 1, 16'(k + 3), 1, 16'(k)));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; out_ready = vecs[i].rdy; halt = vecs[i].halt; redirect = 1'b0;
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_ren", i), 32'(imem_ren), 32'(vecs[i].ren));
                if (vecs[i].ren || vecs[i].rst)
                    chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
                chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
                if (vecs[i].valid) begin
                    chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vecs[i].pc));
                    chk($sformatf("vec%0d_instr", i), 32'(out_instr), 32'(vecs[i].pc ^ 16'hA5A5));
                end
                if (vecs[i].rst) begin
                    chk($sformatf("vec%0d_rst_pc", i), 32'(out_pc), 32'd0);
                    chk($sformatf("vec%0d_rst_instr", i), 32'(out_instr), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            cyc_cnt++;
        end

        // Redirect with three entries buffered and one in flight.
        do_reset();
        out_ready = 1'b0;
        repeat (4) cyc();
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        chk("redir_cycle_ren", 32'(imem_ren), 32'd0);
        chk("redir_pre_valid", 32'(out_valid), 32'd1);
        chk("redir_pre_pc", 32'(out_pc), 32'd0);
        r_cyc = cyc_cnt;
        @(posedge clk); #1; cyc_cnt++;
        redirect = 1'b0; out_ready = 1'b1; clear_got(); mon_en = 1'b1;
        @(negedge clk);
        chk("redir_r1_ren", 32'(imem_ren), 32'd1);
        chk("redir_r1_addr", 32'(imem_addr), 32'h0040);
        chk("redir_r1_valid", 32'(out_valid), 32'd0);
        sample();
        @(posedge clk); #1; cyc_cnt++;
        repeat (10) cyc();
        check_seq("redir", 16'h0040, 4);
        if (got_cyc.size() > 0)
            chk("redir_latency", 32'(got_cyc[0] - r_cyc), 32'(LAT + 1));

        // PC wrap at 16'hFFFF.
        mon_en = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect = 1'b0; clear_got(); mon_en = 1'b1;
        repeat (8) cyc();
        check_seq("wrap", 16'hFFFE, 4);

        // Halt for 5 cycles mid-stream.
        do_reset();
        clear_got(); mon_en = 1'b1;
        repeat (6) cyc();
        halt = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("halt_ren", 32'(imem_ren), 32'd0);
            sample();
            @(posedge clk); #1; cyc_cnt++;
        end
        halt = 1'b0; resume_cyc = cyc_cnt;
        @(negedge clk);
        chk("resume_ren", 32'(imem_ren), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'h0006);
        sample();
        @(posedge clk); #1; cyc_cnt++;
        repeat (8) cyc();
        check_seq("halt", 16'h0000, 12);
        if (got_cyc.size() > 5)
            chk("halt_inflight_landed", 32'(got_cyc[5] < resume_cyc), 32'd1);

        // Halt together with a redirect.
        mon_en = 1'b0; halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
        @(negedge clk);
        chk("halt_redir_ren", 32'(imem_ren), 32'd0);
        @(posedge clk); #1; cyc_cnt++;
        halt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        chk("halt_redir_next_ren", 32'(imem_ren), 32'd1);
        chk("halt_redir_next_addr", 32'(imem_addr), 32'h0010);
        @(posedge clk); #1; cyc_cnt++;

        // Reset pulse with a full FIFO.
        do_reset();
        out_ready = 1'b0;
        repeat (8) cyc();
        rst = 1'b1; out_ready = 1'b1;
        cyc();
        rst = 1'b0; clear_got(); mon_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ren", 32'(imem_ren), 32'd1);
        chk("rst_addr", 32'(imem_addr), 32'h0000);
        sample();
        @(posedge clk); #1; cyc_cnt++;
        repeat (8) cyc();
        check_seq("rst", 16'h0000, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
